// File: rtl/sum_accum_pkg.sv
// Shared types and reset constants for the sum_accum windowed accumulator.
// Optional feature macro used by the slice: SUM_ACCUM_SATURATE_EN.
package sum_accum_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam state_e     RST_STATE = ACCUM;
  localparam logic [7:0] RST_COUNT = 8'd0;
  localparam logic       RST_OVF   = 1'b0;

endpackage

// File: rtl/sum_accum_add.sv
// Accumulator adder: acc + zero-extended sample -> next acc and overflow flag.
// With SUM_ACCUM_SATURATE_EN the result clamps at all-ones; otherwise it wraps.
module sum_accum_add
  import sum_accum_pkg::*;
#(
  parameter int unsigned OUT_W = 16
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [7:0]       sample,
  output logic [OUT_W-1:0] acc_next,
  output logic             ovf
);

`ifdef SUM_ACCUM_SATURATE_EN
  logic [OUT_W:0] sum_wide;

  always_comb begin
    sum_wide = {1'b0, acc} + (OUT_W + 1)'(sample);
    ovf      = sum_wide[OUT_W];
    acc_next = ovf ? '1 : sum_wide[OUT_W-1:0];
  end
`else
  always_comb begin
    acc_next = acc + OUT_W'(sample);
    ovf      = 1'b0;
  end
`endif

endmodule

// File: rtl/sum_accum.sv
// Windowed sample accumulator: sums WINDOW accepted samples (or fewer on flush)
// and holds the total until consumed. Macro SUM_ACCUM_SATURATE_EN selects clamping.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int unsigned WINDOW = 4,   // legal 2..255
  parameter int unsigned OUT_W  = 16   // legal 8..32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       sig_sum,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sig_flush,
  output logic [OUT_W-1:0] out_total,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [7:0] WinCnt = 8'(WINDOW);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] total_q, total_d;
  logic [7:0]       count_q, count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [OUT_W-1:0] add_next;
  logic             add_ovf;
  logic             accept;
  logic [7:0]       cnt_inc;
  logic [OUT_W-1:0] acc_sel;
  logic             ovf_sel;
  logic             close_win;

  sum_accum_add #(
    .OUT_W(OUT_W)
  ) u_add (
    .acc     (acc_q),
    .sample  (sig_sum),
    .acc_next(add_next),
    .ovf     (add_ovf)
  );

  // Both handshake readies are pure functions of state, so neither output
  // has a combinational path from the opposite-side valid/ready.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_total = total_q;
  assign out_count = count_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    accept    = in_valid && (state_q == ACCUM);
    cnt_inc   = cnt_q + {7'd0, accept};
    acc_sel   = accept ? add_next : acc_q;
    ovf_sel   = ovf_q | (accept & add_ovf);
    close_win = (accept && (cnt_inc == WinCnt)) ||
                (sig_flush && ((cnt_q != 8'd0) || accept));
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    total_d   = total_q;
    count_d   = count_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      ACCUM: begin
        acc_d = acc_sel;
        cnt_d = cnt_inc;
        ovf_d = ovf_sel;
        if (close_win) begin
          total_d   = acc_sel;
          count_d   = cnt_inc;
          out_ovf_d = ovf_sel;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = RST_COUNT;
          ovf_d   = RST_OVF;
          state_d = ACCUM;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RST_STATE;
      acc_q     <= '0;
      cnt_q     <= RST_COUNT;
      ovf_q     <= RST_OVF;
      total_q   <= '0;
      count_q   <= RST_COUNT;
      out_ovf_q <= RST_OVF;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      total_q   <= total_d;
      count_q   <= count_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Directed self-checking bench for sum_accum (WINDOW=4, OUT_W=16) plus an OUT_W=8
// instance for overflow; expectations follow SUM_ACCUM_SATURATE_EN when defined.
module tb_sum_accum;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  sig_sum;
  logic        in_valid;
  logic        sig_flush;
  logic        out_ready;
  logic        in_ready;
  logic [15:0] out_total;
  logic [7:0]  out_count;
  logic        out_ovf;
  logic        out_valid;

  logic [7:0]  sig_sum_b;
  logic        in_valid_b;
  logic        sig_flush_b;
  logic        out_ready_b;
  logic        in_ready_b;
  logic [7:0]  out_total_b;
  logic [7:0]  out_count_b;
  logic        out_ovf_b;
  logic        out_valid_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sum_accum #(
    .WINDOW(4),
    .OUT_W (16)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .sig_sum  (sig_sum),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sig_flush(sig_flush),
    .out_total(out_total),
    .out_count(out_count),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  sum_accum #(
    .WINDOW(4),
    .OUT_W (8)
  ) dut8 (
    .clock    (clock),
    .reset_n  (reset_n),
    .sig_sum  (sig_sum_b),
    .in_valid (in_valid_b),
    .in_ready (in_ready_b),
    .sig_flush(sig_flush_b),
    .out_total(out_total_b),
    .out_count(out_count_b),
    .out_ovf  (out_ovf_b),
    .out_valid(out_valid_b),
    .out_ready(out_ready_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    sig_sum  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sig_sum = 8'd0; in_valid = 1'b0; sig_flush = 1'b0; out_ready = 1'b0;
    sig_sum_b = 8'd0; in_valid_b = 1'b0; sig_flush_b = 1'b0; out_ready_b = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_total !== 16'd0 || out_count !== 8'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got total=%0d count=%0d ovf=%b want 0/0/0",
               out_total, out_count, out_ovf);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_window();
    push(8'd10);
    push(8'd20);
    push(8'd30);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL window_partial: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    push(8'd40);
    checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd100 || out_count !== 8'd4) begin
      failures++;
      $display("FAIL window_result: got valid=%b total=%0d count=%0d want 1/100/4",
               out_valid, out_total, out_count);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL window_hold_ready: got %b want 0", in_ready);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL window_release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    push(8'd1);
    push(8'd2);
    push(8'd3);
    push(8'd4);
    sig_sum  = 8'd99;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_total !== 16'd10 || out_count !== 8'd4 ||
          in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stable[%0d]: got valid=%b total=%0d count=%0d ready=%b want 1/10/4/0",
                 i, out_valid, out_total, out_count, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_resume: got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    // An empty flush proves the held-off 99s never entered the window.
    sig_flush = 1'b1;
    tick();
    sig_flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_no_leak: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    push(8'd5);
    push(8'd7);
    sig_flush = 1'b1;
    tick();
    sig_flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd12 || out_count !== 8'd2) begin
      failures++;
      $display("FAIL flush_result: got valid=%b total=%0d count=%0d want 1/12/2",
               out_valid, out_total, out_count);
    end
    sig_flush = 1'b1;
    tick();
    sig_flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd12) begin
      failures++;
      $display("FAIL flush_in_hold: got valid=%b total=%0d want 1/12", out_valid, out_total);
    end
    consume();
    sig_flush = 1'b1;
    tick();
    tick();
    sig_flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    sig_sum   = 8'd9;
    in_valid  = 1'b1;
    sig_flush = 1'b1;
    tick();
    in_valid  = 1'b0;
    sig_flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd9 || out_count !== 8'd1) begin
      failures++;
      $display("FAIL flush_same_cycle: got valid=%b total=%0d count=%0d want 1/9/1",
               out_valid, out_total, out_count);
    end
    consume();
  endtask

  task automatic test_overflow();
    logic [7:0] vec [4];
    logic [7:0] exp_total;
    logic       exp_ovf;
    vec[0] = 8'd255; vec[1] = 8'd255; vec[2] = 8'd1; vec[3] = 8'd1;
`ifdef SUM_ACCUM_SATURATE_EN
    exp_total = 8'd255;
    exp_ovf   = 1'b1;
`else
    exp_total = 8'd0;
    exp_ovf   = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      sig_sum_b  = vec[i];
      in_valid_b = 1'b1;
      tick();
    end
    in_valid_b = 1'b0;
    checks++;
    if (out_valid_b !== 1'b1 || out_total_b !== exp_total || out_count_b !== 8'd4) begin
      failures++;
      $display("FAIL ovf_total: got valid=%b total=%0d count=%0d want 1/%0d/4",
               out_valid_b, out_total_b, out_count_b, exp_total);
    end
    checks++;
    if (out_ovf_b !== exp_ovf) begin
      failures++; $display("FAIL ovf_flag: got %b want %b", out_ovf_b, exp_ovf);
    end
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    checks++;
    if (out_valid_b !== 1'b0) begin
      failures++; $display("FAIL ovf_release: got valid=%b want 0", out_valid_b);
    end
  endtask

  task automatic test_reset_mid();
    push(8'd100);
    push(8'd100);
    push(8'd100);
    push(8'd100);
    checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd400) begin
      failures++;
      $display("FAIL rst_pre_hold: got valid=%b total=%0d want 1/400", out_valid, out_total);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_total !== 16'd0) begin
      failures++;
      $display("FAIL rst_async_hold: got valid=%b total=%0d want 0/0", out_valid, out_total);
    end
    tick();
    reset_n = 1'b1;
    push(8'd50);
    push(8'd60);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_window: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    push(8'd1);
    push(8'd2);
    push(8'd3);
    push(8'd4);
    checks++;
    if (out_valid !== 1'b1 || out_total !== 16'd10 || out_count !== 8'd4) begin
      failures++;
      $display("FAIL rst_next_window: got valid=%b total=%0d count=%0d want 1/10/4",
               out_valid, out_total, out_count);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_window();
    test_backpressure();
    test_flush();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
